// File: rtl/ram64_arb_pkg.sv
// Shared types and constants for the RAM64 two-port arbiter.
// The saturating increment helper is only used when RAM64_ARB_STATS_EN is defined.
package ram64_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Request captured at the handshake; held until the next grant so the RAM pins stay quiet.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              port;
  } req_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == STAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ram64_arb_rr.sv
// Combinational two-way round-robin picker: a lone requester wins,
// on a conflict the port that was not granted last wins.
module ram64_arb_rr (
  input  logic [1:0] i_valid,
  input  logic       i_lastGrant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_lastGrant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram64_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a RAM64 block.
// Define RAM64_ARB_STATS_EN to add saturating grant/conflict counters.
module ram64_arbiter
  import ram64_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0]                   req_we_i,
  input  logic [1:0][ADDR_W-1:0]       req_addr_i,
  input  logic [1:0][WIDTH-1:0]        req_wdata_i,
  output logic [1:0]                   rsp_valid_o,
  output logic [WIDTH-1:0]             rsp_rdata_o,
  output logic [ADDR_W-1:0]            ram_address_o,
  output logic [WIDTH-1:0]             ram_in_o,
  output logic                         ram_load_o,
  input  logic [WIDTH-1:0]             ram_out_i
`ifdef RAM64_ARB_STATS_EN
  ,
  output logic [1:0][15:0]             stat_grant_o,
  output logic [15:0]                  stat_conflict_o
`endif
);

  state_t           r_state;
  state_t           w_stateNext;
  req_t             r_req;
  logic             r_lastGrant;
  logic [1:0]       r_rspValid;
  logic [WIDTH-1:0] r_rdata;
  logic [1:0]       w_grant;
  logic [1:0]       w_ready;
  logic             w_handshake;
  logic             w_winner;

  ram64_arb_rr u_rr (
    .i_valid     (req_valid_i),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant)
  );

  // Ready is only offered in IDLE and never while reset is held.
  always_comb begin
    w_stateNext = r_state;
    w_ready     = 2'b00;
    case (r_state)
      IDLE: begin
        if (!rst_i) begin
          w_ready = w_grant;
        end
        if (w_ready != 2'b00) begin
          w_stateNext = ACCESS;
        end
      end
      ACCESS:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_handshake = |w_ready;
  assign w_winner    = w_ready[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_lastGrant <= 1'b1;
      r_rspValid  <= 2'b00;
      r_rdata     <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_rspValid <= 2'b00;
      if (w_handshake) begin
        r_req.we    <= req_we_i[w_winner];
        r_req.addr  <= req_addr_i[w_winner];
        r_req.wdata <= req_wdata_i[w_winner];
        r_req.port  <= w_winner;
        r_lastGrant <= w_winner;
      end
      // The RAM read is combinational, so its data is captured during ACCESS itself.
      if (r_state == ACCESS) begin
        r_rspValid[r_req.port] <= 1'b1;
        if (!r_req.we) begin
          r_rdata <= ram_out_i;
        end
      end
    end
  end

  assign req_ready_o   = w_ready;
  assign rsp_valid_o   = r_rspValid;
  assign rsp_rdata_o   = r_rdata;
  assign ram_address_o = r_req.addr;
  assign ram_in_o      = r_req.wdata;
  assign ram_load_o    = (r_state == ACCESS) && r_req.we && !rst_i;

`ifdef RAM64_ARB_STATS_EN
  logic [1:0][15:0] r_statGrant;
  logic [15:0]      r_statConflict;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_statGrant    <= '0;
      r_statConflict <= '0;
    end else begin
      if (w_handshake) begin
        r_statGrant[w_winner] <= satInc(r_statGrant[w_winner]);
      end
      if ((r_state == IDLE) && (req_valid_i == 2'b11)) begin
        r_statConflict <= satInc(r_statConflict);
      end
    end
  end

  assign stat_grant_o    = r_statGrant;
  assign stat_conflict_o = r_statConflict;
`endif

endmodule

// File: doc/ram64_arbiter.md
# ram64_arbiter

Two-port arbiter and access sequencer for the RAM64 memory block. It takes read/write requests from two independent requesters over a valid/ready handshake and grants them round-robin. It drives RAM64's `in_i`/`load_i`/`address_i` inputs, captures `out_o` for reads, and returns a single-cycle response to the granted requester. It sits between the CPU-side masters and the RAM64 instance at the memory-subsystem top, and does not instantiate RAM64 itself.

## Interface
Parameters:
- `WIDTH`, default 16: data word width, matching RAM64 `WIDTH`.
- `ADDR_W`, default 6: RAM64 address width (64 words).

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_valid_i`, in, [1:0]: per-port request valid.
- `req_ready_o`, out, [1:0]: per-port request accepted this cycle; one-hot or zero.
- `req_we_i`, in, [1:0]: per-port request type; 1 = write, 0 = read.
- `req_addr_i`, in, [1:0][ADDR_W-1:0]: per-port word address.
- `req_wdata_i`, in, [1:0][WIDTH-1:0]: per-port write data.
- `rsp_valid_o`, out, [1:0]: per-port one-cycle response pulse; there is no back-pressure.
- `rsp_rdata_o`, out, WIDTH: read data, valid while `rsp_valid_o` is nonzero on a read.
- `ram_address_o`, out, ADDR_W: connects to RAM64 `address_i`.
- `ram_in_o`, out, WIDTH: connects to RAM64 `in_i`.
- `ram_load_o`, out, 1: connects to RAM64 `load_i`.
- `ram_out_i`, in, WIDTH: connects from RAM64 `out_o` (combinational read).

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE:**
  - The arbiter selects a winner among the asserted `req_valid_i` bits.
  - It asserts `req_ready_o[winner]` combinationally.
  - On the handshake it latches `we`, `addr`, `wdata` and the port index, then goes to ACCESS.
  - With no valid request it stays in IDLE.
- **ACCESS:**
  - `ram_address_o` = latched address; `ram_in_o` = latched data; `ram_load_o` = latched `we`.
  - On a read, `ram_out_i` is registered into `rsp_rdata_o`.
  - `rsp_valid_o[port]` is registered high for the next cycle.
  - The FSM always returns to IDLE next cycle.
- **Round-robin:** `last_grant` register.
  - A single requester always wins.
  - When both are valid, the port ≠ `last_grant` wins.
  - `last_grant` updates only on a handshake.
- `req_ready_o` is 0 in ACCESS. Requesters hold valid and payload stable until ready.
- Writes also return `rsp_valid_o`; `rsp_rdata_o` then holds its previous value.
- Outside ACCESS: `ram_load_o`=0. `ram_address_o`/`ram_in_o` hold their last latched values, so there are no glitches into RAM64.

## Timing
- Handshake at edge N (cycle N: IDLE, valid & ready) → RAM access in cycle N+1 → `rsp_valid_o` high in cycle N+2 for exactly one cycle.
- The RAM64 write commits at the end of cycle N+1.
- Throughput: one access per 2 cycles. A new handshake may occur in cycle N+2 concurrently with the response.
- Reset values: state=IDLE; `req_ready_o`=0 while `rst_i` is high; `rsp_valid_o`=0; `rsp_rdata_o`=0; `ram_load_o`=0; `ram_address_o`=0; `ram_in_o`=0; `last_grant`=1, so port 0 wins the first conflict.
- Reset mid-ACCESS: the access is abandoned. `ram_load_o` is 0 in the reset cycle, so no write occurs and no response is issued.
- Simultaneous requests: the loser sees `req_ready_o`=0 and is granted at the next IDLE if still valid. Starvation is bounded to one access.
- Address range 0–63 uses full `ADDR_W` decode, with no wrap logic needed.

## Configuration
- `RAM64_ARB_STATS_EN` **defined:** adds the following outputs, all cleared by `rst_i`:
  - `stat_grant_o` [1:0][15:0]: per-port handshake counters.
  - `stat_conflict_o` [15:0]: counts IDLE cycles with both valid.
  - Counters saturate at 16'hFFFF.
- **Undefined:** the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `ram64_arb_pkg`:
  - `NUM_PORTS`=2, `ADDR_W`=6.
  - `state_t` enum {IDLE, ACCESS}.
  - Latched-request struct `req_t` {we, addr, wdata, port}.
- Sub-module `ram64_arb_rr`: combinational two-way round-robin picker; inputs valid[1:0] and `last_grant`; outputs a one-hot grant.

## Test plan
- **Reset then single write:** port0 write addr=5, data=16'hABCD → ready0 in cycle 0, `ram_load_o`=1 at addr 5 in cycle 1, `rsp_valid_o`=2'b01 in cycle 2. A subsequent port1 read addr=5 returns 16'hABCD.
- **Simultaneous requests after reset:** both ports read addr=0/1 → port0 granted first, port1 at the next IDLE. Responses arrive 2 cycles apart in order 01, 10.
- **Persistent contention:** both ports hold valid for 8 accesses → grants alternate 0,1,0,1…; neither port gets two consecutive grants.
- **Back-to-back single port:** port1 writes 64 addresses (data = addr ^ 16'h5A5A) then reads all 64 → every read matches; a handshake occurs every 2 cycles.
- **Reset mid-ACCESS:** assert `rst_i` during the ACCESS of a write to addr 10 → no `ram_load_o` pulse, no `rsp_valid_o`; a later read of addr 10 returns the pre-write value.
- **With `RAM64_ARB_STATS_EN` defined:** 3 conflicts and 5 port0 grants → `stat_conflict_o`=3, `stat_grant_o[0]`=5. Forcing overflow holds the counter at 16'hFFFF.
